// File: rtl/mcpu_mem_ltc_pkg.sv
// Shared types for the LTC data/tag line RAM.
package mcpu_mem_ltc_pkg;

  localparam int unsigned LTC_LINE_BYTES = 32;

  typedef logic [LTC_LINE_BYTES-1:0][7:0] ltc_line_t;
  typedef logic [LTC_LINE_BYTES-1:0]      ltc_be_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ltc_bram_state_e;

endpackage

// File: rtl/mcpu_mem_ltc_bram_core.sv
// Reset-free byte-enabled storage array with a registered read port.
// Both ports are read-before-write, so a same-address read returns the old line.
module mcpu_mem_ltc_bram_core
  import mcpu_mem_ltc_pkg::*;
#(
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned DEPTH_BITS  = 9,
  parameter int unsigned WIDTH_BYTES = LTC_LINE_BYTES
) (
  input  logic                     clk_i,
  input  logic [DEPTH_BITS-1:0]    waddr_i,
  input  logic [WIDTH_BYTES-1:0]   wbe_i,
  input  logic [WIDTH_BYTES*8-1:0] wdata_i,
  input  logic                     re_i,
  input  logic [DEPTH_BITS-1:0]    raddr_i,
  output logic [WIDTH_BYTES*8-1:0] rdata_o
);

  logic [WIDTH_BYTES*8-1:0] mem_q [DEPTH];
  logic [WIDTH_BYTES*8-1:0] rdata_q;

  // Per-byte-lane write into the array.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < WIDTH_BYTES; i++) begin
      if (wbe_i[i]) begin
        mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  // Registered read, holds when no read is issued.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mcpu_mem_ltc_bram_pipe.sv
// LTC line RAM wrapper: init sequencer, init/external write mux, same-cycle
// collision bypass and 1- or 2-cycle read latency around the storage core.
module mcpu_mem_ltc_bram_pipe
  import mcpu_mem_ltc_pkg::*;
#(
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned DEPTH_BITS  = 9,
  parameter int unsigned WIDTH_BYTES = LTC_LINE_BYTES,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned BYPASS      = 1
) (
  input  logic                     clkrst_mem_clk,
  input  logic                     clkrst_mem_rst,
  input  logic                     init_req,
  output logic                     ready,
  input  logic [DEPTH_BITS-1:0]    waddr,
  input  logic [WIDTH_BYTES-1:0]   wbe,
  input  logic [WIDTH_BYTES*8-1:0] wdata,
  input  logic                     re,
  input  logic [DEPTH_BITS-1:0]    raddr,
  output logic                     rvalid,
  output logic [WIDTH_BYTES*8-1:0] rdata
);

  localparam int unsigned DW = WIDTH_BYTES * 8;

  ltc_bram_state_e         state_q, state_d;
  logic [DEPTH_BITS-1:0]   cnt_q, cnt_d;

  logic [WIDTH_BYTES-1:0]  mem_wbe;
  logic [DEPTH_BITS-1:0]   mem_waddr;
  logic [DW-1:0]           mem_wdata;
  logic                    rd_acc;
  logic [DW-1:0]           core_rdata;

  logic                    rvalid1_q;
  logic                    rd_seen_q;
  logic [WIDTH_BYTES-1:0]  coll_be_q;
  logic [DW-1:0]           coll_data_q;
  logic [DW-1:0]           merged;
  logic                    coll_hit;

  // State and init counter register.
  always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
    if (clkrst_mem_rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: sweep every line once, then run until a re-init request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + DEPTH_BITS'(1);
        if (cnt_q == DEPTH_BITS'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (init_req) begin
          cnt_d   = '0;
          state_d = INIT;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: init owns the write port and blocks external traffic.
  always_comb begin
    ready     = 1'b0;
    mem_wbe   = '0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    rd_acc    = 1'b0;
    case (state_q)
      INIT: begin
        mem_wbe   = '1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
      end
      RUN: begin
        ready   = 1'b1;
        mem_wbe = wbe;
        rd_acc  = re;
      end
      default: ;
    endcase
  end

  mcpu_mem_ltc_bram_core #(
    .DEPTH       (DEPTH),
    .DEPTH_BITS  (DEPTH_BITS),
    .WIDTH_BYTES (WIDTH_BYTES)
  ) u_core (
    .clk_i   (clkrst_mem_clk),
    .waddr_i (mem_waddr),
    .wbe_i   (mem_wbe),
    .wdata_i (mem_wdata),
    .re_i    (rd_acc),
    .raddr_i (raddr),
    .rdata_o (core_rdata)
  );

  assign coll_hit = (BYPASS != 0) && (waddr == raddr);

  // Capture read acceptance and any same-edge write bytes to overlay.
  always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
    if (clkrst_mem_rst) begin
      rvalid1_q   <= 1'b0;
      rd_seen_q   <= 1'b0;
      coll_be_q   <= '0;
      coll_data_q <= '0;
    end else begin
      rvalid1_q <= rd_acc;
      if (rd_acc) begin
        rd_seen_q   <= 1'b1;
        coll_be_q   <= coll_hit ? wbe : '0;
        coll_data_q <= wdata;
      end
    end
  end

  // Byte-granular overlay of the new write data on the old line. The core
  // has no reset, so the result is forced to zero until a read completes.
  always_comb begin
    merged = '0;
    for (int unsigned i = 0; i < WIDTH_BYTES; i++) begin
      merged[8*i +: 8] = coll_be_q[i] ? coll_data_q[8*i +: 8] : core_rdata[8*i +: 8];
    end
    if (!rd_seen_q) begin
      merged = '0;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic          rvalid2_q;
    logic [DW-1:0] rdata2_q;

    // Extra output stage, loaded only by a completing read.
    always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
      if (clkrst_mem_rst) begin
        rvalid2_q <= 1'b0;
        rdata2_q  <= '0;
      end else begin
        rvalid2_q <= rvalid1_q;
        if (rvalid1_q) begin
          rdata2_q <= merged;
        end
      end
    end

    assign rvalid = rvalid2_q;
    assign rdata  = rdata2_q;
  end else begin : g_lat1
    assign rvalid = rvalid1_q;
    assign rdata  = merged;
  end

endmodule

// File: tb/tb_mcpu_mem_ltc_bram_pipe.sv
// Bench for the LTC line RAM: two instances (latency 1 with bypass, latency 2
// without) share stimulus and are checked every cycle against a line-level model.
module tb_mcpu_mem_ltc_bram_pipe;

  localparam int DEPTH = 512;
  localparam int DB    = 9;
  localparam int WB    = 32;
  localparam int DW    = WB * 8;
  localparam int NMAX  = 16384;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_req = 1'b0;
  logic          re = 1'b0;
  logic [DB-1:0] waddr = '0;
  logic [DB-1:0] raddr = '0;
  logic [WB-1:0] wbe = '0;
  logic [DW-1:0] wdata = '0;

  logic          readyA, rvalidA, readyB, rvalidB;
  logic [DW-1:0] rdataA, rdataB;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mcpu_mem_ltc_bram_pipe #(
    .DEPTH(DEPTH), .DEPTH_BITS(DB), .WIDTH_BYTES(WB), .RD_LATENCY(1), .BYPASS(1)
  ) uA (
    .clkrst_mem_clk(clk), .clkrst_mem_rst(rst), .init_req(init_req), .ready(readyA),
    .waddr(waddr), .wbe(wbe), .wdata(wdata), .re(re), .raddr(raddr),
    .rvalid(rvalidA), .rdata(rdataA)
  );

  mcpu_mem_ltc_bram_pipe #(
    .DEPTH(DEPTH), .DEPTH_BITS(DB), .WIDTH_BYTES(WB), .RD_LATENCY(2), .BYPASS(0)
  ) uB (
    .clkrst_mem_clk(clk), .clkrst_mem_rst(rst), .init_req(init_req), .ready(readyB),
    .waddr(waddr), .wbe(wbe), .wdata(wdata), .re(re), .raddr(raddr),
    .rvalid(rvalidB), .rdata(rdataB)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem [DEPTH];
  bit            acc   [NMAX];
  logic [DW-1:0] d_new [NMAX];   // result with same-edge write merged in
  logic [DW-1:0] d_old [NMAX];   // result from the stored line only
  int            n = 0;
  int            base = 0;       // first edge after the latest reset release
  int            left = DEPTH;
  bit            m_ready = 1'b0;
  logic [DW-1:0] lastA = '0;
  logic [DW-1:0] lastB = '0;

  always begin : model
    logic [DW-1:0] old_l, new_l;
    bit vA, vB;
    @(posedge clk);
    n++;
    if (n >= NMAX) begin
      $display("FAIL edge_budget: actual=%0d required<%0d", n, NMAX);
      $fatal(1, "edge budget exhausted");
    end
    acc[n] = 1'b0;
    if (rst) begin
      m_ready = 1'b0;
      left    = DEPTH;
      base    = n + 1;
      lastA   = '0;
      lastB   = '0;
      for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
    end else if (!m_ready) begin
      left--;
      if (left == 0) m_ready = 1'b1;
    end else begin
      if (re) begin
        old_l = m_mem[raddr];
        new_l = old_l;
        if (waddr == raddr)
          for (int b = 0; b < WB; b++) if (wbe[b]) new_l[8*b +: 8] = wdata[8*b +: 8];
        acc[n]   = 1'b1;
        d_old[n] = old_l;
        d_new[n] = new_l;
      end
      for (int b = 0; b < WB; b++) if (wbe[b]) m_mem[waddr][8*b +: 8] = wdata[8*b +: 8];
      if (init_req) begin
        m_ready = 1'b0;
        left    = DEPTH;
        for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
      end
    end
    #1;
    vA = (n >= base) && acc[n];
    vB = (n - 1 >= base) && (n >= 1) && acc[n-1];
    if (vA) lastA = d_new[n];
    if (vB) lastB = d_old[n-1];
    chk("A_ready",  readyA,  m_ready);
    chk("A_rvalid", rvalidA, vA);
    chk("A_rdata",  rdataA,  lastA);
    chk("B_ready",  readyB,  m_ready);
    chk("B_rvalid", rvalidB, vB);
    chk("B_rdata",  rdataB,  lastB);
  end

  // ---------------- directed + random stimulus ----------------
  task automatic idle();
    re = 1'b0; wbe = '0; init_req = 1'b0;
  endtask

  task automatic wait_ready(output int c);
    c = 0;
    while (!readyA && c < 2000) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    waddr = DB'(a); wbe = '1; wdata = d;
    @(negedge clk);
    wbe = '0;
  endtask

  initial begin : stim
    int cyc;
    logic [DW-1:0] pat, exp_m, l11, l99;
    idle();
    repeat (3) @(negedge clk);
    chk("rst_readyA",  readyA,  1'b0);
    chk("rst_rvalidA", rvalidA, 1'b0);
    chk("rst_rdataA",  rdataA,  '0);
    chk("rst_rvalidB", rvalidB, 1'b0);
    chk("rst_rdataB",  rdataB,  '0);

    // release with a read held on address 0 throughout init
    rst = 1'b0; re = 1'b1; raddr = '0;
    wait_ready(cyc);
    chk("init_len", cyc, 512);
    @(negedge clk);
    re = 1'b0;
    chk("first_rd_A_valid", rvalidA, 1'b1);
    chk("first_rd_A_data",  rdataA,  '0);
    @(negedge clk);
    chk("first_rd_B_valid", rvalidB, 1'b1);
    chk("first_rd_B_data",  rdataB,  '0);

    // full-line write then read
    pat = {8{32'hDEADBEEF}};
    wr(5, pat);
    re = 1'b1; raddr = 5; @(negedge clk); re = 1'b0;
    chk("wr5_A_valid", rvalidA, 1'b1);
    chk("wr5_A_data",  rdataA,  pat);
    chk("wr5_B_early", rvalidB, 1'b0);
    @(negedge clk);
    chk("wr5_B_valid", rvalidB, 1'b1);
    chk("wr5_B_data",  rdataB,  pat);
    chk("wr5_A_pulse", rvalidA, 1'b0);

    // same-edge collision on address 7
    l11 = {32{8'h11}};
    exp_m = {{28{8'h11}}, {4{8'hAA}}};
    wr(7, l11);
    waddr = 7; wbe = 32'h0000000F; wdata = {32{8'hAA}}; re = 1'b1; raddr = 7;
    @(negedge clk);
    idle();
    chk("coll_A_bypass", rdataA, exp_m);
    @(negedge clk);
    chk("coll_B_old", rdataB, l11);
    re = 1'b1; raddr = 7; @(negedge clk); re = 1'b0;
    chk("coll_A_after", rdataA, exp_m);
    @(negedge clk);
    chk("coll_B_after", rdataB, exp_m);

    // back-to-back reads of 1,2,3
    for (int i = 1; i <= 3; i++) begin
      pat = '0;
      for (int b = 0; b < WB; b++) pat[8*b +: 8] = 8'(i);
      wr(i, pat);
    end
    for (int i = 1; i <= 3; i++) begin
      pat = '0;
      for (int b = 0; b < WB; b++) pat[8*b +: 8] = 8'(i);
      re = 1'b1; raddr = DB'(i);
      @(negedge clk);
      chk("b2b_A_valid", rvalidA, 1'b1);
      chk("b2b_A_data",  rdataA,  pat);
    end
    re = 1'b0;
    @(negedge clk);
    chk("b2b_A_end", rvalidA, 1'b0);

    // re-init with a read of line 9 in flight on the request edge
    l99 = {32{8'h99}};
    wr(9, l99);
    init_req = 1'b1; re = 1'b1; raddr = 9;
    @(negedge clk);
    idle();
    chk("reinit_ready_fall", readyA, 1'b0);
    chk("reinit_A_inflight", rdataA, l99);
    @(negedge clk);
    chk("reinit_B_inflight", rdataB, l99);
    repeat (298) @(negedge clk);
    // late in the sweep, past line 9: these writes must be dropped
    waddr = 9; wbe = '1; wdata = '1;
    repeat (5) @(negedge clk);
    wbe = '0;
    wait_ready(cyc);
    chk("reinit_len", 304 + cyc, 512);
    re = 1'b1; raddr = 9; @(negedge clk); re = 1'b0;
    chk("reinit_A_line9", rdataA, '0);

    // reset during a latency-2 read in flight
    wr(5, {8{32'hCAFEF00D}});
    re = 1'b1; raddr = 5;
    @(posedge clk);
    #2;
    re = 1'b0; rst = 1'b1;
    #1;
    chk("rst_rd_A_valid", rvalidA, 1'b0);
    chk("rst_rd_A_data",  rdataA,  '0);
    chk("rst_rd_B_valid", rvalidB, 1'b0);
    chk("rst_rd_B_data",  rdataB,  '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset again with the sweep at line 100
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_init_ready", readyA, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ready(cyc);
    chk("rst_init_len", cyc, 512);

    // randomized traffic on a small address window to provoke collisions
    repeat (3000) begin
      re    = 1'($urandom_range(0, 1));
      raddr = DB'($urandom_range(0, 7));
      waddr = DB'($urandom_range(0, 7));
      wbe   = ($urandom_range(0, 2) == 0) ? '0 : WB'($urandom);
      for (int w = 0; w < DW / 32; w++) wdata[32*w +: 32] = $urandom;
      init_req = ($urandom_range(0, 999) == 0);
      @(negedge clk);
    end
    idle();
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
